// File: rtl/input_vector_sequencer.sv
// ============================================================================
//  Module   : input_vector_sequencer
//  Purpose  : Upstream feeder for LINEAR_LAYER. Captures one input vector of
//             NUM_UNKNOWNS extended-float words through a valid/ready load
//             port, then replays the vector element by element NUM_PASSES
//             times (once per output neuron) onto INPUT_SCALER. FIRST/LAST
//             frame each pass so the accumulator can clear and emit.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   system clock, rising edge
//    RESET        in   asynchronous, active-low reset
//    LOAD_DATA    in   vector element being loaded ({exception bits, IEEE word})
//    LOAD_VALID   in   LOAD_DATA valid
//    LOAD_READY   out  element is accepted this cycle (state LOAD)
//    START        in   begin streaming the buffered vector (WAIT_START only)
//    HOLD         in   downstream stall; freezes streaming
//    INPUT_SCALER out  element to LINEAR_LAYER
//    SCALER_VALID out  INPUT_SCALER valid this cycle
//    FIRST        out  element index 0 of a pass (accumulator clear)
//    LAST         out  element index NUM_UNKNOWNS-1 of a pass
//    PASS_IDX     out  pass number of the current output
//    BUSY         out  state is not LOAD
//    DONE         out  one-cycle pulse, coincident with the final LAST
// ============================================================================
`default_nettype none

module input_vector_sequencer #(
  parameter int BIT_WIDTH    = 32,
  parameter int EXTRA_BITS   = 2,
  parameter int NUM_UNKNOWNS = 2,
  parameter int NUM_PASSES   = 2,
  localparam int WORD_W      = BIT_WIDTH + EXTRA_BITS,
  localparam int PASS_W      = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] LOAD_DATA,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic              START,
  input  logic              HOLD,
  output logic [WORD_W-1:0] INPUT_SCALER,
  output logic              SCALER_VALID,
  output logic              FIRST,
  output logic              LAST,
  output logic [PASS_W-1:0] PASS_IDX,
  output logic              BUSY,
  output logic              DONE
);

  localparam int IDX_W = (NUM_UNKNOWNS > 1) ? $clog2(NUM_UNKNOWNS) : 1;

  localparam logic [IDX_W-1:0]  LAST_ELEM = IDX_W'(NUM_UNKNOWNS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  elem_idx;
  logic [PASS_W-1:0] pass_idx;
  logic [WORD_W-1:0] vec_buf [NUM_UNKNOWNS];

  logic load_fire;

  // Status outputs decode straight from the state register so that an
  // asynchronous reset clears them without waiting for a clock edge.
  assign LOAD_READY = (state == ST_LOAD);
  assign BUSY       = (state != ST_LOAD);
  assign DONE       = (state == ST_DONE);

  assign load_fire  = (state == ST_LOAD) && LOAD_VALID;

  // --------------------------------------------------------------------------
  // Vector buffer: one register per element, written only while loading.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_UNKNOWNS; i++) begin : g_buf
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          vec_buf[i] <= '0;
        end else if (load_fire && (load_idx == IDX_W'(i))) begin
          vec_buf[i] <= LOAD_DATA;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM, counters and registered stream outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_LOAD;
      load_idx     <= '0;
      elem_idx     <= '0;
      pass_idx     <= '0;
      INPUT_SCALER <= '0;
      SCALER_VALID <= 1'b0;
      FIRST        <= 1'b0;
      LAST         <= 1'b0;
      PASS_IDX     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (LOAD_VALID) begin
            if (load_idx == LAST_ELEM) begin
              load_idx <= '0;
              state    <= ST_WAIT;
            end else begin
              load_idx <= load_idx + IDX_W'(1);
            end
          end
        end

        ST_WAIT: begin
          if (START) begin
            elem_idx <= '0;
            pass_idx <= '0;
            state    <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (HOLD) begin
            // Stall: drop the qualifiers but keep data/pass index stable.
            SCALER_VALID <= 1'b0;
            FIRST        <= 1'b0;
            LAST         <= 1'b0;
          end else begin
            INPUT_SCALER <= vec_buf[elem_idx];
            SCALER_VALID <= 1'b1;
            FIRST        <= (elem_idx == '0);
            LAST         <= (elem_idx == LAST_ELEM);
            PASS_IDX     <= pass_idx;
            if (elem_idx == LAST_ELEM) begin
              elem_idx <= '0;
              if (pass_idx == LAST_PASS) begin
                // Final element is registered now; DONE lines up with it.
                pass_idx <= '0;
                state    <= ST_DONE;
              end else begin
                pass_idx <= pass_idx + PASS_W'(1);
              end
            end else begin
              elem_idx <= elem_idx + IDX_W'(1);
            end
          end
        end

        ST_DONE: begin
          // HOLD is deliberately not consulted here.
          SCALER_VALID <= 1'b0;
          FIRST        <= 1'b0;
          LAST         <= 1'b0;
          state        <= ST_LOAD;
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_input_vector_sequencer.sv
// ============================================================================
//  Module   : tb_input_vector_sequencer
//  Purpose  : Self-checking bench for input_vector_sequencer using per-cycle
//             expected-output tables plus directed load/reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_vector_sequencer;

  localparam logic [33:0] VA = 34'h13f9d70a4;  // {01, 1.23}
  localparam logic [33:0] VB = 34'h13e4ccccd;  // {01, 0.2}
  localparam logic [33:0] VC = 34'h000000000;  // {00, 0}
  localparam logic [33:0] VD = 34'h1bf800000;  // {01, -1.0}
  localparam logic [33:0] JUNK = 34'h2deadbeef;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [33:0] LOAD_DATA;
  logic        LOAD_VALID;
  logic        LOAD_READY;
  logic        START;
  logic        HOLD;
  logic [33:0] INPUT_SCALER;
  logic        SCALER_VALID;
  logic        FIRST;
  logic        LAST;
  logic [0:0]  PASS_IDX;
  logic        BUSY;
  logic        DONE;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        hold;
    logic        valid;
    logic [33:0] data;
    logic        first;
    logic        last;
    logic        pass;
    logic        done;
    logic        ready;
  } vec_t;

  vec_t tbl[$];

  input_vector_sequencer #(
    .BIT_WIDTH   (32),
    .EXTRA_BITS  (2),
    .NUM_UNKNOWNS(2),
    .NUM_PASSES  (2)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .LOAD_DATA   (LOAD_DATA),
    .LOAD_VALID  (LOAD_VALID),
    .LOAD_READY  (LOAD_READY),
    .START       (START),
    .HOLD        (HOLD),
    .INPUT_SCALER(INPUT_SCALER),
    .SCALER_VALID(SCALER_VALID),
    .FIRST       (FIRST),
    .LAST        (LAST),
    .PASS_IDX    (PASS_IDX),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic h, input logic v, input logic [33:0] d, input logic f,
                     input logic l, input logic p, input logic dn, input logic r);
    vec_t e;
    e.hold = h; e.valid = v; e.data = d; e.first = f;
    e.last = l; e.pass = p; e.done = dn; e.ready = r;
    tbl.push_back(e);
  endtask

  task automatic check_row(input string tag, input int i);
    chk($sformatf("%s[%0d] valid", tag, i), 64'(SCALER_VALID), 64'(tbl[i].valid));
    chk($sformatf("%s[%0d] data",  tag, i), 64'(INPUT_SCALER), 64'(tbl[i].data));
    chk($sformatf("%s[%0d] first", tag, i), 64'(FIRST),        64'(tbl[i].first));
    chk($sformatf("%s[%0d] last",  tag, i), 64'(LAST),         64'(tbl[i].last));
    chk($sformatf("%s[%0d] pass",  tag, i), 64'(PASS_IDX),     64'(tbl[i].pass));
    chk($sformatf("%s[%0d] done",  tag, i), 64'(DONE),         64'(tbl[i].done));
    chk($sformatf("%s[%0d] ready", tag, i), 64'(LOAD_READY),   64'(tbl[i].ready));
    chk($sformatf("%s[%0d] busy",  tag, i), 64'(BUSY),         64'(!tbl[i].ready));
  endtask

  // START in cycle k, then compare table rows from cycle k+2 onward.
  task automatic start_and_run(input string tag, input int first_row, input int n);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk({tag, " k+1 valid"}, 64'(SCALER_VALID), 64'(0));
    tick();
    for (int i = first_row; i < first_row + n; i++) begin
      HOLD = tbl[i].hold;
      check_row(tag, i);
      tick();
    end
    HOLD = 1'b0;
  endtask

  task automatic load_two(input logic [33:0] a, input logic [33:0] b);
    LOAD_VALID = 1'b1;
    LOAD_DATA  = a;
    tick();
    LOAD_DATA  = b;
    tick();
    LOAD_VALID = 1'b0;
    LOAD_DATA  = JUNK;
  endtask

  initial begin
    // Basic two-pass stream, rows 0..5
    add(0, 1, VA, 1, 0, 0, 0, 0);
    add(0, 1, VB, 0, 1, 0, 0, 0);
    add(0, 1, VA, 1, 0, 1, 0, 0);
    add(0, 1, VB, 0, 1, 1, 1, 0);
    add(0, 0, VB, 0, 0, 1, 0, 1);
    add(0, 0, VB, 0, 0, 1, 0, 1);
    // HOLD for 3 cycles after first valid, rows 6..13
    add(1, 1, VA, 1, 0, 0, 0, 0);
    add(1, 0, VA, 0, 0, 0, 0, 0);
    add(1, 0, VA, 0, 0, 0, 0, 0);
    add(0, 0, VA, 0, 0, 0, 0, 0);
    add(0, 1, VB, 0, 1, 0, 0, 0);
    add(0, 1, VA, 1, 0, 1, 0, 0);
    add(0, 1, VB, 0, 1, 1, 1, 0);
    add(0, 0, VB, 0, 0, 1, 0, 1);
    // Second vector with zero exception bits, rows 14..18
    add(0, 1, VC, 1, 0, 0, 0, 0);
    add(0, 1, VD, 0, 1, 0, 0, 0);
    add(0, 1, VC, 1, 0, 1, 0, 0);
    add(0, 1, VD, 0, 1, 1, 1, 0);
    add(0, 0, VD, 0, 0, 1, 0, 1);

    RESET = 1'b0; LOAD_DATA = '0; LOAD_VALID = 1'b0; START = 1'b0; HOLD = 1'b0;
    tick();
    tick();
    chk("rst valid", 64'(SCALER_VALID), 64'(0));
    chk("rst data",  64'(INPUT_SCALER), 64'(0));
    chk("rst first", 64'(FIRST),        64'(0));
    chk("rst last",  64'(LAST),         64'(0));
    chk("rst pass",  64'(PASS_IDX),     64'(0));
    chk("rst busy",  64'(BUSY),         64'(0));
    chk("rst done",  64'(DONE),         64'(0));
    RESET = 1'b1;
    #1;
    chk("post-rst ready", 64'(LOAD_READY), 64'(1));

    // Load handshake: VALID 1,0,1 with a START pulse that must be ignored.
    LOAD_VALID = 1'b1; LOAD_DATA = VA; START = 1'b1;
    tick();
    LOAD_VALID = 1'b0; LOAD_DATA = JUNK; START = 1'b0;
    chk("hs ready after 1st", 64'(LOAD_READY), 64'(1));
    tick();
    LOAD_VALID = 1'b1; LOAD_DATA = VB;
    chk("hs ready gap", 64'(LOAD_READY), 64'(1));
    tick();
    LOAD_VALID = 1'b0;
    chk("hs ready after 2nd", 64'(LOAD_READY), 64'(0));
    chk("hs busy after 2nd",  64'(BUSY),       64'(1));
    // Extra VALID in WAIT_START must not touch the buffer.
    LOAD_VALID = 1'b1; LOAD_DATA = JUNK;
    tick();
    LOAD_VALID = 1'b0;
    chk("wait ready", 64'(LOAD_READY), 64'(0));
    chk("wait valid", 64'(SCALER_VALID), 64'(0));

    start_and_run("basic", 0, 6);

    // HOLD stall
    load_two(VA, VB);
    start_and_run("hold", 6, 8);

    // Reset during pass 1, element 0
    load_two(VA, VB);
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    tick();
    chk("mid pre valid", 64'(SCALER_VALID), 64'(1));
    chk("mid pre pass",  64'(PASS_IDX),     64'(1));
    chk("mid pre first", 64'(FIRST),        64'(1));
    #2;
    RESET = 1'b0;
    #1;
    chk("mid async valid", 64'(SCALER_VALID), 64'(0));
    chk("mid async data",  64'(INPUT_SCALER), 64'(0));
    chk("mid async first", 64'(FIRST),        64'(0));
    chk("mid async pass",  64'(PASS_IDX),     64'(0));
    chk("mid async busy",  64'(BUSY),         64'(0));
    chk("mid async done",  64'(DONE),         64'(0));
    tick();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post-mid[%0d] done", i),  64'(DONE),         64'(0));
      chk($sformatf("post-mid[%0d] valid", i), 64'(SCALER_VALID), 64'(0));
      chk($sformatf("post-mid[%0d] ready", i), 64'(LOAD_READY),   64'(1));
      tick();
    end
    load_two(VA, VB);
    start_and_run("fresh", 0, 6);

    // Back-to-back vector with START pulsed while loading.
    LOAD_VALID = 1'b1; LOAD_DATA = VC; START = 1'b1;
    tick();
    LOAD_VALID = 1'b0; LOAD_DATA = JUNK;
    chk("b2b ready mid-load", 64'(LOAD_READY), 64'(1));
    tick();
    START = 1'b0; LOAD_VALID = 1'b1; LOAD_DATA = VD;
    chk("b2b ready before 2nd", 64'(LOAD_READY), 64'(1));
    tick();
    LOAD_VALID = 1'b0; LOAD_DATA = JUNK;
    chk("b2b ready loaded", 64'(LOAD_READY), 64'(0));
    tick();
    chk("b2b no early stream", 64'(SCALER_VALID), 64'(0));
    start_and_run("b2b", 14, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
